// File: rtl/cpu_defs.sv
// Shared CPU definitions for the MEM-stage exception arbiter.
// Build option: EXC_ARB_TLB_EN enables TLB exceptions, the refill vector and TLB ops.
package cpu_defs;

    typedef enum logic [3:0] {
        OP_NONE, OP_EXC, OP_BADVA, OP_TLB_EXC, OP_ERET, OP_MTC0, OP_TLBW, OP_TLBR, OP_TLBP
    } cp0_op_t;

    typedef enum logic [2:0] {TLB_NONE, TLB_WI, TLB_WR, TLB_R, TLB_P} tlb_req_t;

    typedef enum logic [2:0] {NO_EXC, REFILL_L, REFILL_S, INVALID_L, INVALID_S, MODIFIED} tlb_exc_t;

    typedef struct packed {
        logic [1:0] addr_err;    // 01 fetch AdEL, 10 data AdEL, 11 AdES
        logic       ri;
        logic       ov;
        logic       bp;
        logic       sys;
        logic       eret;
        logic       mtc0;
        tlb_req_t   tlb_req;
        tlb_exc_t   tlb_exc_if;
        tlb_exc_t   tlb_exc_mem;
    } exc_flags_t;

    typedef enum logic {IDLE, FLUSH} exc_arb_state_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

`ifdef EXC_ARB_TLB_EN
    localparam bit TLB_EN = 1'b1;
`else
    localparam bit TLB_EN = 1'b0;
`endif

endpackage

// File: rtl/exc_arbiter_prio_enc.sv
// Per-slot exception priority encoder: flags + interrupt bit -> {is_exc, op, code, is_refill}.
module exc_prio_enc
    import cpu_defs::*;
(
    input  exc_flags_t  flags,
    input  logic        int_pend,
    output logic        is_exc,
    output cp0_op_t     op,
    output logic [4:0]  code,
    output logic        is_refill
);

    tlb_exc_t tlb_if;
    tlb_exc_t tlb_mem;
    tlb_req_t tlb_req;

    // Without TLB support the TLB fields read as idle.
    assign tlb_if  = TLB_EN ? flags.tlb_exc_if  : NO_EXC;
    assign tlb_mem = TLB_EN ? flags.tlb_exc_mem : NO_EXC;
    assign tlb_req = TLB_EN ? flags.tlb_req     : TLB_NONE;

    always_comb begin
        is_exc    = 1'b1;
        op        = OP_EXC;
        code      = EXC_INT;
        is_refill = 1'b0;
        if (int_pend) begin
            code = EXC_INT;
        end else if (flags.addr_err == 2'b01) begin
            op   = OP_BADVA;
            code = EXC_ADEL;
        end else if (tlb_if != NO_EXC) begin
            op        = OP_TLB_EXC;
            code      = EXC_TLBL;
            is_refill = (tlb_if == REFILL_L) || (tlb_if == REFILL_S);
        end else if (flags.ri) begin
            code = EXC_RI;
        end else if (flags.ov) begin
            code = EXC_OV;
        end else if (flags.bp) begin
            code = EXC_BP;
        end else if (flags.sys) begin
            code = EXC_SYS;
        end else if (flags.addr_err != 2'b00) begin
            op   = OP_BADVA;
            code = (flags.addr_err == 2'b11) ? EXC_ADES : EXC_ADEL;
        end else if (tlb_mem != NO_EXC) begin
            op = OP_TLB_EXC;
            case (tlb_mem)
                REFILL_L:  begin code = EXC_TLBL; is_refill = 1'b1; end
                REFILL_S:  begin code = EXC_TLBS; is_refill = 1'b1; end
                INVALID_L: code = EXC_TLBL;
                INVALID_S: code = EXC_TLBS;
                default:   code = EXC_MOD;
            endcase
        end else begin
            is_exc = 1'b0;
            code   = 5'd0;
            if (flags.eret)      op = OP_ERET;
            else if (flags.mtc0) op = OP_MTC0;
            else begin
                case (tlb_req)
                    TLB_WI, TLB_WR: op = OP_TLBW;
                    TLB_R:          op = OP_TLBR;
                    TLB_P:          op = OP_TLBP;
                    default:        op = OP_NONE;
                endcase
            end
        end
    end

endmodule

// File: rtl/exc_arbiter.sv
// Multi-slot precise-exception arbiter: oldest-slot selection, interrupt sync, CP0 commit + flush handshake.
// Build option: EXC_ARB_TLB_EN (see cpu_defs).
module exc_arbiter
    import cpu_defs::*;
#(
    parameter int          NSLOT       = 2,
    parameter logic [31:0] EXC_BASE    = 32'hBFC00380,
    parameter logic [31:0] REFILL_BASE = 32'hBFC00200,
    parameter int          INT_SYNC    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [5:0]                  ext_int,
    input  logic [NSLOT-1:0]            slot_valid,
    input  logic [NSLOT-1:0][31:0]      slot_pc,
    input  logic [NSLOT-1:0][31:0]      slot_pcminus4,
    input  logic [NSLOT-1:0]            slot_bd,
    input  logic [NSLOT-1:0][31:0]      slot_badvaddr,
    input  exc_flags_t [NSLOT-1:0]      slot_flags,
    input  logic [31:0]                 cp0_status,
    input  logic [31:0]                 cp0_cause,
    input  logic [31:0]                 cp0_epc,
    input  logic                        flush_ack,
    output logic                        commit_valid,
    output logic                        commit_exc,
    output cp0_op_t                     commit_op,
    output logic [4:0]                  commit_code,
    output logic [31:0]                 commit_epc,
    output logic                        commit_bd,
    output logic [31:0]                 commit_badvaddr,
    output logic [31:0]                 commit_target,
    output logic [NSLOT-1:0]            kill_mask,
    output logic                        flush_req
);

    localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [INT_SYNC-1:0][5:0] int_sync;
    logic [7:0]               ip;
    logic                     int_pend;
    logic                     exl;
    logic                     unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_sync <= '0;
        end else begin
            int_sync[0] <= ext_int;
            for (int i = 1; i < INT_SYNC; i++) int_sync[i] <= int_sync[i-1];
        end
    end

    assign exl         = cp0_status[1];
    assign ip          = {int_sync[INT_SYNC-1], cp0_cause[9:8]};
    assign int_pend    = (|(ip & cp0_status[15:8])) && cp0_status[0] && !exl;
    assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[30:10], cp0_cause[7:0]};

    logic [NSLOT-1:0]          s_exc, s_refill, cand;
    cp0_op_t [NSLOT-1:0]       s_op;
    logic [NSLOT-1:0][4:0]     s_code;

    // Interrupts are taken only on the oldest slot, and only when it holds a real instruction.
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        exc_prio_enc u_enc (
            .flags     (slot_flags[g]),
            .int_pend  ((g == 0) ? (int_pend & slot_valid[0]) : 1'b0),
            .is_exc    (s_exc[g]),
            .op        (s_op[g]),
            .code      (s_code[g]),
            .is_refill (s_refill[g])
        );
        assign cand[g] = slot_valid[g] && (s_exc[g] || (s_op[g] != OP_NONE));
    end

    logic              has_win;
    logic [IW-1:0]     win;
    logic [NSLOT-1:0]  kill;

    always_comb begin
        has_win = 1'b0;
        win     = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                has_win = 1'b1;
                win     = IW'(i);
            end
        end
        kill = '0;
        for (int i = 0; i < NSLOT; i++) kill[i] = has_win && (i > int'(win));
    end

    logic [31:0] epc_nx, bva_nx, tgt_nx;
    logic        bd_nx;

    always_comb begin
        epc_nx = exl ? cp0_epc : (slot_bd[win] ? slot_pcminus4[win] : slot_pc[win]);
        bd_nx  = exl ? cp0_cause[31] : slot_bd[win];
        bva_nx = ((TLB_EN && (slot_flags[win].tlb_exc_if != NO_EXC)) || (slot_flags[win].addr_err == 2'b01))
                 ? slot_pc[win] : slot_badvaddr[win];
        if (s_op[win] == OP_ERET)          tgt_nx = cp0_epc;
        else if (s_refill[win] && !exl)    tgt_nx = REFILL_BASE;
        else                               tgt_nx = EXC_BASE;
    end

    exc_arb_state_t state, state_nx;
    logic           commit_en;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        commit_en = 1'b0;
        case (state)
            IDLE: begin
                if (has_win) begin
                    commit_en = 1'b1;
                    if (s_exc[win] || (s_op[win] == OP_ERET)) state_nx = FLUSH;
                end
            end
            FLUSH:   if (flush_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign flush_req = (state == FLUSH);

    // Record fields hold their last value between commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid    <= 1'b0;
            commit_exc      <= 1'b0;
            commit_op       <= OP_NONE;
            commit_code     <= 5'd0;
            commit_epc      <= 32'd0;
            commit_bd       <= 1'b0;
            commit_badvaddr <= 32'd0;
            commit_target   <= EXC_BASE;
            kill_mask       <= '0;
        end else begin
            commit_valid <= commit_en;
            kill_mask    <= commit_en ? kill : '0;
            if (commit_en) begin
                commit_exc      <= s_exc[win];
                commit_op       <= s_op[win];
                commit_code     <= s_code[win];
                commit_epc      <= epc_nx;
                commit_bd       <= bd_nx;
                commit_badvaddr <= bva_nx;
                commit_target   <= tgt_nx;
            end
        end
    end

endmodule

// File: tb/tb_exc_arbiter.sv
// Scoreboard bench for exc_arbiter: directed cases plus random traffic vs a behavioural model.
module tb_exc_arbiter;
    import cpu_defs::*;

    localparam int          NSLOT       = 2;
    localparam int          INT_SYNC    = 2;
    localparam logic [31:0] EXC_BASE    = 32'hBFC00380;
    localparam logic [31:0] REFILL_BASE = 32'hBFC00200;
`ifdef EXC_ARB_TLB_EN
    localparam bit TB_TLB = 1'b1;
`else
    localparam bit TB_TLB = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [5:0]             ext_int;
    logic [NSLOT-1:0]       slot_valid, slot_bd, kill_mask;
    logic [NSLOT-1:0][31:0] slot_pc, slot_pcminus4, slot_badvaddr;
    exc_flags_t [NSLOT-1:0] slot_flags;
    logic [31:0]            cp0_status, cp0_cause, cp0_epc;
    logic                   flush_ack, commit_valid, commit_exc, commit_bd, flush_req;
    cp0_op_t                commit_op;
    logic [4:0]             commit_code;
    logic [31:0]            commit_epc, commit_badvaddr, commit_target;

    exc_arbiter #(.NSLOT(NSLOT), .EXC_BASE(EXC_BASE), .REFILL_BASE(REFILL_BASE), .INT_SYNC(INT_SYNC)) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int), .slot_valid(slot_valid), .slot_pc(slot_pc),
        .slot_pcminus4(slot_pcminus4), .slot_bd(slot_bd), .slot_badvaddr(slot_badvaddr),
        .slot_flags(slot_flags), .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .flush_ack(flush_ack), .commit_valid(commit_valid), .commit_exc(commit_exc), .commit_op(commit_op),
        .commit_code(commit_code), .commit_epc(commit_epc), .commit_bd(commit_bd),
        .commit_badvaddr(commit_badvaddr), .commit_target(commit_target), .kill_mask(kill_mask),
        .flush_req(flush_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                   rst;
        logic [5:0]             ext_int;
        logic [NSLOT-1:0]       valid, bd;
        logic [NSLOT-1:0][31:0] pc, pcm4, bva;
        exc_flags_t [NSLOT-1:0] flags;
        logic [31:0]            status, cause, epc;
        logic                   ack;
    } stim_t;

    typedef struct {
        logic             exc;
        cp0_op_t          op;
        logic [4:0]       code;
        logic [31:0]      epc, bva, target;
        logic             bd;
        logic [NSLOT-1:0] kill;
    } exp_t;

    typedef struct {
        bit         exc;
        cp0_op_t    op;
        logic [4:0] code;
        bit         refill;
    } sres_t;

    exp_t       cq[$];
    bit         fq[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] hist [0:8191];
    int         edge_n = 0;
    int         last_rst = -100;
    bit         m_flush = 1'b0;
    logic [5:0] cur_ext = 6'd0;

    // Exception causes in decreasing priority, then the plain CP0 ops.
    function automatic sres_t ref_slot(exc_flags_t f, bit intp);
        sres_t    r;
        tlb_exc_t fi, fm;
        tlb_req_t rq;
        fi = TB_TLB ? f.tlb_exc_if : NO_EXC;
        fm = TB_TLB ? f.tlb_exc_mem : NO_EXC;
        rq = TB_TLB ? f.tlb_req : TLB_NONE;
        r.exc = 1'b1; r.refill = 1'b0; r.op = OP_EXC; r.code = EXC_INT;
        if (intp) r.code = EXC_INT;
        else if (f.addr_err == 2'b01) begin r.op = OP_BADVA; r.code = EXC_ADEL; end
        else if (fi != NO_EXC) begin
            r.op = OP_TLB_EXC; r.code = EXC_TLBL; r.refill = fi inside {REFILL_L, REFILL_S};
        end
        else if (f.ri)  r.code = EXC_RI;
        else if (f.ov)  r.code = EXC_OV;
        else if (f.bp)  r.code = EXC_BP;
        else if (f.sys) r.code = EXC_SYS;
        else if (f.addr_err != 2'b00) begin
            r.op = OP_BADVA; r.code = (f.addr_err == 2'b11) ? EXC_ADES : EXC_ADEL;
        end
        else if (fm != NO_EXC) begin
            r.op = OP_TLB_EXC;
            r.refill = fm inside {REFILL_L, REFILL_S};
            r.code = (fm == MODIFIED) ? EXC_MOD : (fm inside {REFILL_S, INVALID_S}) ? EXC_TLBS : EXC_TLBL;
        end
        else begin
            r.exc = 1'b0; r.code = 5'd0;
            r.op = f.eret ? OP_ERET : f.mtc0 ? OP_MTC0 : (rq inside {TLB_WI, TLB_WR}) ? OP_TLBW :
                   (rq == TLB_R) ? OP_TLBR : (rq == TLB_P) ? OP_TLBP : OP_NONE;
        end
        return r;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s.rst = 1'b0; s.ext_int = 6'd0; s.valid = '0; s.bd = '0;
        s.pc = '0; s.pcm4 = '0; s.bva = '0; s.flags = '0;
        s.status = 32'd0; s.cause = 32'd0; s.epc = 32'd0; s.ack = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = blank();
        s.rst = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 9) == 0) cur_ext = 6'($urandom);
        s.ext_int = cur_ext;
        s.valid = NSLOT'($urandom);
        s.bd = NSLOT'($urandom);
        for (int i = 0; i < NSLOT; i++) begin
            s.pc[i]   = {$urandom} & 32'hFFFF_FFFC;
            s.pcm4[i] = s.pc[i] - 32'd4;
            s.bva[i]  = $urandom;
            s.flags[i].ri   = ($urandom_range(0, 7) == 0);
            s.flags[i].ov   = ($urandom_range(0, 7) == 0);
            s.flags[i].bp   = ($urandom_range(0, 7) == 0);
            s.flags[i].sys  = ($urandom_range(0, 7) == 0);
            s.flags[i].eret = ($urandom_range(0, 7) == 0);
            s.flags[i].mtc0 = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0) s.flags[i].addr_err = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) s.flags[i].tlb_req = tlb_req_t'(3'($urandom_range(1, 4)));
            if ($urandom_range(0, 9) == 0) s.flags[i].tlb_exc_if = tlb_exc_t'(3'($urandom_range(1, 5)));
            if ($urandom_range(0, 7) == 0) s.flags[i].tlb_exc_mem = tlb_exc_t'(3'($urandom_range(1, 5)));
        end
        s.status = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
        s.cause  = {1'($urandom), 21'h0, ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00, 8'h0};
        s.epc    = $urandom;
        s.ack    = ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the coming edge.
    task automatic step(input stim_t s);
        sres_t      r [NSLOT];
        exp_t       e;
        logic [5:0] sync;
        bit         intp, exl;
        int         w;
        @(negedge clk);
        rst = s.rst; ext_int = s.ext_int; slot_valid = s.valid; slot_bd = s.bd;
        slot_pc = s.pc; slot_pcminus4 = s.pcm4; slot_badvaddr = s.bva; slot_flags = s.flags;
        cp0_status = s.status; cp0_cause = s.cause; cp0_epc = s.epc; flush_ack = s.ack;
        hist[edge_n] = s.ext_int;
        if (s.rst) begin
            last_rst = edge_n;
            m_flush  = 1'b0;
        end else if (m_flush) begin
            if (s.ack) m_flush = 1'b0;
        end else begin
            sync = (edge_n - INT_SYNC > last_rst) ? hist[edge_n - INT_SYNC] : 6'd0;
            exl  = s.status[1];
            intp = s.valid[0] && (({sync, s.cause[9:8]} & s.status[15:8]) != 8'd0) && s.status[0] && !exl;
            w = -1;
            for (int i = 0; i < NSLOT; i++) begin
                r[i] = ref_slot(s.flags[i], (i == 0) && intp);
                if (w < 0 && s.valid[i] && (r[i].exc || r[i].op != OP_NONE)) w = i;
            end
            if (w >= 0) begin
                e.exc  = r[w].exc;
                e.op   = r[w].op;
                e.code = r[w].code;
                e.epc  = exl ? s.epc : (s.bd[w] ? s.pcm4[w] : s.pc[w]);
                e.bd   = exl ? s.cause[31] : s.bd[w];
                e.bva  = ((TB_TLB && s.flags[w].tlb_exc_if != NO_EXC) || s.flags[w].addr_err == 2'b01) ? s.pc[w] : s.bva[w];
                e.target = (r[w].op == OP_ERET) ? s.epc : (r[w].refill && !exl) ? REFILL_BASE : EXC_BASE;
                for (int i = 0; i < NSLOT; i++) e.kill[i] = (i > w);
                cq.push_back(e);
                m_flush = r[w].exc || (r[w].op == OP_ERET);
            end
        end
        fq.push_back(m_flush);
        edge_n++;
    endtask

    task automatic drain();
        stim_t s;
        s = blank();
        s.ack = 1'b1;
        repeat (4) step(s);
    endtask

    initial begin : monitor
        bit   ef;
        exp_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            if (fq.size() > 0) begin
                ef = fq.pop_front();
                checks++;
                if (flush_req !== ef) begin
                    errors++;
                    $display("FAIL flush_req: got %b need %b at edge %0d", flush_req, ef, edge_n);
                end
            end
            if (commit_valid === 1'b1) begin
                checks++;
                if (cq.size() == 0) begin
                    errors++;
                    $display("FAIL commit: unexpected commit op=%0d code=%0d, need none", commit_op, commit_code);
                end else begin
                    e  = cq.pop_front();
                    ok = (commit_exc === e.exc) && (commit_op === e.op) && (kill_mask === e.kill);
                    if (e.exc)
                        ok = ok && (commit_code === e.code) && (commit_epc === e.epc) && (commit_bd === e.bd)
                                && (commit_badvaddr === e.bva) && (commit_target === e.target);
                    if (e.op == OP_ERET) ok = ok && (commit_target === e.target);
                    if (!ok) begin
                        errors++;
                        $display("FAIL commit: got exc=%b op=%0d code=%0d epc=%h bd=%b bva=%h tgt=%h kill=%b need exc=%b op=%0d code=%0d epc=%h bd=%b bva=%h tgt=%h kill=%b",
                                 commit_exc, commit_op, commit_code, commit_epc, commit_bd, commit_badvaddr, commit_target, kill_mask,
                                 e.exc, e.op, e.code, e.epc, e.bd, e.bva, e.target, e.kill);
                    end
                end
            end else begin
                checks++;
                if (kill_mask !== '0) begin
                    errors++;
                    $display("FAIL kill_idle: got %b need 0", kill_mask);
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        s = blank();
        s.rst = 1'b1;
        step(s);
        step(s);
        @(posedge clk);
        #2;
        checks++;
        if (commit_valid !== 1'b0 || commit_exc !== 1'b0 || commit_op !== OP_NONE || commit_code !== 5'd0 ||
            commit_epc !== 32'd0 || commit_bd !== 1'b0 || commit_badvaddr !== 32'd0 ||
            commit_target !== EXC_BASE || kill_mask !== '0 || flush_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b tgt=%h kill=%b flush=%b need v=0 tgt=%h kill=0 flush=0",
                     commit_valid, commit_target, kill_mask, flush_req, EXC_BASE);
        end

        // Slot0 RI beats slot1 Sys; slot1 is killed.
        s = blank();
        s.valid = 2'b11; s.pc[0] = 32'h8000_1000; s.pc[1] = 32'h8000_1004;
        s.flags[0].ri = 1'b1; s.flags[1].sys = 1'b1;
        step(s);
        drain();

        // Clean slot0, Ov in a delay slot on slot1.
        s = blank();
        s.valid = 2'b11; s.bd[1] = 1'b1; s.pc[1] = 32'h8000_2004; s.pcm4[1] = 32'h8000_2000;
        s.flags[1].ov = 1'b1;
        step(s);
        drain();

        // External interrupt with IM2/IE set, then the same with EXL=1.
        s = blank();
        s.valid = 2'b01; s.ext_int = 6'b000001; s.status = 32'h0000_0401;
        repeat (4) step(s);
        drain();
        drain();
        s.status = 32'h0000_0403;
        repeat (4) step(s);
        drain();
        drain();

        // ERET redirects to EPC; MTC0 on slot1 commits without flushing.
        s = blank();
        s.valid = 2'b01; s.flags[0].eret = 1'b1; s.epc = 32'h8000_9000;
        step(s);
        drain();
        s = blank();
        s.valid = 2'b10; s.flags[1].mtc0 = 1'b1;
        step(s);
        step(blank());

`ifdef EXC_ARB_TLB_EN
        s = blank();
        s.valid = 2'b01; s.pc[0] = 32'h8000_3000; s.bva[0] = 32'h1234_5678;
        s.flags[0].tlb_exc_mem = REFILL_S;
        step(s);
        drain();
        s.status = 32'h0000_0002; s.epc = 32'h8000_5000;
        step(s);
        drain();
`endif

        // Bp during FLUSH is ignored, including the cycle carrying flush_ack.
        s = blank();
        s.valid = 2'b01; s.flags[0].bp = 1'b1; s.pc[0] = 32'h8000_4000;
        step(s);
        step(s);
        step(s);
        s.ack = 1'b1;
        step(s);
        s.ack = 1'b0;
        step(s);
        drain();

        // Reset while flushing abandons the flush.
        s = blank();
        s.valid = 2'b01; s.flags[0].sys = 1'b1;
        step(s);
        s.rst = 1'b1;
        step(s);
        s.rst = 1'b0;
        step(s);
        drain();

        repeat (700) step(rand_stim());
        drain();
        @(posedge clk);
        #3;
        checks++;
        if (cq.size() != 0) begin
            errors++;
            $display("FAIL missing_commits: got %0d outstanding need 0", cq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_arbiter.md
# exc_arbiter

Multi-slot precise-exception arbiter for the memory stage; successor to the single-slot exception handler. Sits between the MEM-stage slot bundle and CP0. Per cycle it selects the oldest excepting slot among `NSLOT` issue slots, synchronises external interrupts, and registers one commit record per cycle toward CP0. It then holds the pipeline in a flush handshake until the front end acknowledges the redirect.

## Interface
Parameters:
- `NSLOT`, 2: issue slots; slot 0 is oldest.
- `EXC_BASE`, 32'hBFC00380: general exception vector.
- `REFILL_BASE`, 32'hBFC00200: TLB refill vector, used when EXL=0.
- `INT_SYNC`, 2: synchroniser flops on `ext_int` (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ext_int` in 6: asynchronous hardware interrupt lines.
- `slot_valid` in NSLOT: slot holds a real instruction.
- `slot_pc` in NSLOT×32: PC per slot.
- `slot_pcminus4` in NSLOT×32: PC−4 per slot.
- `slot_bd` in NSLOT: slot is in a delay slot.
- `slot_badvaddr` in NSLOT×32: data address per slot.
- `slot_flags` in NSLOT×`exc_flags_t`: addr_err, ri, ov, bp, sys, eret, mtc0, tlb_req, tlb_exc_if, tlb_exc_mem.
- `cp0_status` in 32: CP0 Status.
- `cp0_cause` in 32: CP0 Cause.
- `cp0_epc` in 32: CP0 EPC.
- `flush_ack` in 1: front end has applied the redirect.
- `commit_valid` out 1: one-cycle pulse; commit record valid.
- `commit_exc` out 1: the record is an exception, not a plain op.
- `commit_op` out `cp0_op_t`: operation for CP0.
- `commit_code` out 5: ExcCode.
- `commit_epc` out 32: EPC value.
- `commit_bd` out 1: Cause.BD value.
- `commit_badvaddr` out 32: BadVAddr value.
- `commit_target` out 32: redirect PC.
- `kill_mask` out NSLOT: younger slots to squash.
- `flush_req` out 1: level, held until acknowledged.

## Operation
- Interrupt path:
  - `ext_int` passes through `INT_SYNC` flops.
  - `ip = {sync_int, cause[9:8]}`.
  - Interrupt is pending when `(ip & status[15:8]) != 0`, `status[0]=1` and `status[1]=0`.
  - A pending interrupt attaches to slot 0 only, and only when `slot_valid[0]`.
- Per-slot priority, highest first:
  - INT
  - AdEL-fetch (addr_err=01)
  - TLBL refill-if, TLBL invalid-if
  - RI, Ov, Bp, Sys
  - AdEL-data (10), AdES (11)
  - TLB-mem: refill L/S, invalid L/S, Mod
- If a slot has no exception, it produces a non-exception op in this order: ERET → OP_ERET, MTC0 → OP_MTC0, TLBWI/TLBWR → OP_TLBW, TLBR, TLBP, else NONE.
- Winner selection: the lowest-index valid slot with an exception or a non-NONE op. All higher-index slots are set in `kill_mask`.
- EPC/BD:
  - If EXL=1: epc=`cp0_epc`, bd=`cause[31]`.
  - Else, if the slot has bd set: epc=pcminus4, bd=1.
  - Else: epc=pc, bd=0.
- BadVAddr: slot_pc if tlb_exc_if≠NO_EXC or addr_err=01; otherwise slot_badvaddr.
- Target:
  - Refill (fetch or mem) with EXL=0 → `REFILL_BASE`.
  - Other exceptions → `EXC_BASE`.
  - ERET → `cp0_epc`.
  - Non-flushing ops → don't care.
- CP0 op per exception: INT/RI/Ov/Bp/Sys → OP_EXC; AdE* → OP_BADVA; TLB* → OP_TLB_EXC.
- FSM with two states:
  - IDLE: a winner that is an exception or ERET → FLUSH, asserting `flush_req`. Any other winner commits and stays in IDLE.
  - FLUSH: all slot inputs and interrupts are ignored and no commits are issued. `flush_ack` → IDLE.

## Timing
- Inputs are sampled at edge t. The commit record, `kill_mask` and `flush_req` are registered and appear in cycle t+1.
- `commit_valid` is high for exactly one cycle.
- `flush_req` rises together with `commit_valid` and stays high until the cycle after `flush_ack` is sampled.
- `flush_ack` sampled in IDLE is ignored.
- Slot inputs presented in the same cycle as `flush_ack` are still ignored. Evaluation resumes the following cycle.
- Interrupt latency from an `ext_int` edge to commit is at most `INT_SYNC`+1 cycles, given slot 0 is valid and the FSM is in IDLE.
- Reset state:
  - FSM=IDLE.
  - All outputs 0, except `commit_target`=`EXC_BASE`.
  - Synchroniser cleared.
  - Reset in FLUSH abandons the flush without a commit.
- No valid slots → no commit, `kill_mask`=0.

## Configuration
- `EXC_ARB_TLB_EN` defined: TLB fetch and mem exceptions, `REFILL_BASE`, and the TLBW/TLBR/TLBP ops are all active.
- Undefined:
  - The tlb fields of `slot_flags` are ignored.
  - `REFILL_BASE` is never selected.
  - tlb_req produces NONE.
  - Port list is unchanged.

## Structure
- `cpu_defs` package holds:
  - `exc_flags_t`
  - existing `cp0_op_t`, `tlb_req_t`, `tlb_exc_t`
  - EXCCODE constants
  - `exc_arb_state_t` {IDLE, FLUSH}
- Sub-module `exc_prio_enc`, one instance per slot, is combinational. It maps flags plus the int-pending bit to {is_exc, op, code, is_refill}.

## Test plan
- Slot0 RI, slot1 Sys, EXL=0, slot0 pc=0x80001000 → next cycle: code=RI, epc=0x80001000, bd=0, `kill_mask`=10, target=0xBFC00380, `flush_req`=1.
- Slot0 clean ADDU, slot1 bd=1 with Ov, pcminus4=0x80002000 → code=Ov, epc=0x80002000, bd=1, `kill_mask`=00.
- `ext_int[0]` rises with IM2=1, IE=1, EXL=0, slot0 valid; `INT_SYNC`=2 → commit code=INT within 3 cycles. The same stimulus with EXL=1 produces no commit.
- Slot0 tlb_exc_mem=REFILL_S with EXL=0 → code=TLBS, target=0xBFC00200. With EXL=1 → target=0xBFC00380, epc=`cp0_epc`.
- During FLUSH, apply slot0 Bp → no commit. Assert `flush_ack` → IDLE one cycle later, then the next Bp commits.
- Assert `rst` while in FLUSH → next cycle `flush_req`=0, `commit_valid`=0, FSM=IDLE.
